// File: rtl/tx_logic_pkg.sv
// ---------------------------------------------------------------------------
// tx_logic_pkg
// Definitions shared by the router transmit side (tx_logic) and the receive
// side (rx_logic_2): item width, number of output ports, position of the
// destination-port field inside an item and the legal port encodings.
// No ports; imported with `import tx_logic_pkg::*;`.
// ---------------------------------------------------------------------------
package tx_logic_pkg;

    localparam int DATA_SIZE = 8;  // default item width in bits
    localparam int NUM_PORTS = 5;  // output ports per router
    localparam int PORT_LSB  = 0;  // destination field is item[PORT_LSB +: PORT_W]
    localparam int PORT_W    = 3;

    typedef enum logic [PORT_W-1:0] {
        PORT_0 = 3'd0,
        PORT_1 = 3'd1,
        PORT_2 = 3'd2,
        PORT_3 = 3'd3,
        PORT_4 = 3'd4
    } port_e;

    localparam logic [PORT_W-1:0] PORT_LAST = PORT_4;

    // Field values above the last encoded port (5..7) address nothing.
    function automatic logic port_is_valid(input logic [PORT_W-1:0] field);
        return field <= PORT_LAST;
    endfunction

endpackage

// File: rtl/tx_logic_port.sv
// ---------------------------------------------------------------------------
// tx_port
// State of one two-phase output port: the request toggle register and the
// data register presented to the receiver.
//   clk, reset : clock, asynchronous active-high reset
//   send       : load item and toggle req at the next edge (only when free)
//   item       : item to present on this port
//   ack        : receiver's two-phase acknowledge (synchronous to clk)
//   req        : two-phase request; a toggle announces a new item
//   data       : item held for the receiver
//   busy       : req != ack, i.e. an item is outstanding
// ---------------------------------------------------------------------------
module tx_port
    import tx_logic_pkg::*;
#(
    parameter int SIZE = DATA_SIZE
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            send,
    input  logic [SIZE-1:0] item,
    input  logic            ack,
    output logic            req,
    output logic [SIZE-1:0] data,
    output logic            busy
);

    // An ack toggle while not busy simply makes req != ack; the port then
    // reads as busy until the next ack, exactly as the phase rule says.
    assign busy = req ^ ack;

    // data only moves together with a req toggle, so it is stable for the
    // whole time the port is busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req  <= 1'b0;
            data <= '0;
        end else if (send) begin
            req  <= ~req;
            data <= item;
        end
    end

endmodule

// File: rtl/tx_logic.sv
// ---------------------------------------------------------------------------
// tx_logic
// Pops items from a first-word-fall-through FIFO and hands each one to the
// output port named by its destination field, using a two-phase req/ack
// handshake per port. Items with an unencoded port field are discarded and
// counted.
//   clk, reset    : clock, asynchronous active-high reset
//   fifo_empty    : upstream FIFO holds no item
//   fifo_item_out : FIFO head item, valid while fifo_empty is low
//   fifo_read     : one-cycle pop strobe
//   tx_req        : per-port two-phase request
//   tx_ack        : per-port two-phase acknowledge
//   tx_data       : per-port data, port p in [SIZE*p +: SIZE]
//   drop          : one-cycle pulse when an item is discarded
//   drop_count    : saturating count of discarded items
//
// Handshake: port p is busy while tx_req[p] != tx_ack[p]. A send toggles
// tx_req[p] and loads slot p in the same edge; the receiver toggles
// tx_ack[p] once it has taken the data, which frees the port.
// ---------------------------------------------------------------------------
module tx_logic
    import tx_logic_pkg::*;
#(
    parameter int id   = -1,
    parameter int SIZE = DATA_SIZE
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      fifo_empty,
    input  logic [SIZE-1:0]           fifo_item_out,
    output logic                      fifo_read,
    output logic [NUM_PORTS-1:0]      tx_req,
    input  logic [NUM_PORTS-1:0]      tx_ack,
    output logic [NUM_PORTS*SIZE-1:0] tx_data,
    output logic                      drop,
    output logic [7:0]                drop_count
);

    // id only labels the parent router; no hardware depends on it.
    if (id < -1) begin : g_id_unused
    end

    logic [PORT_W-1:0]    port_field;
    logic                 port_ok;
    logic                 decide;
    logic                 drop_now;
    logic [NUM_PORTS-1:0] busy;
    logic [NUM_PORTS-1:0] send_en;

    assign port_field = fifo_item_out[PORT_LSB +: PORT_W];
    assign port_ok    = port_is_valid(port_field);

    // While fifo_read is high the FIFO head still shows the item being
    // popped, so no decision is taken in that cycle (one bubble per pop).
    assign decide   = !fifo_empty && !fifo_read;
    assign drop_now = decide && !port_ok;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        // A busy head port leaves send_en low, which stalls the whole FIFO.
        assign send_en[p] = decide && (port_field == PORT_W'(p)) && !busy[p];

        tx_port #(
            .SIZE (SIZE)
        ) u_port (
            .clk   (clk),
            .reset (reset),
            .send  (send_en[p]),
            .item  (fifo_item_out),
            .ack   (tx_ack[p]),
            .req   (tx_req[p]),
            .data  (tx_data[SIZE*p +: SIZE]),
            .busy  (busy[p])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_read  <= 1'b0;
            drop       <= 1'b0;
            drop_count <= 8'd0;
        end else begin
            fifo_read <= (|send_en) || drop_now;
            drop      <= drop_now;
            if (drop_now && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_tx_logic.sv
// ---------------------------------------------------------------------------
// tb_tx_logic
// Directed bench for tx_logic with a FWFT FIFO model, an expected-item
// scoreboard popped by a monitor on every fifo_read pulse, and a simple
// two-phase receiver model for the end-to-end run.
// ---------------------------------------------------------------------------
module tb_tx_logic;
    import tx_logic_pkg::*;

    localparam int SIZE = 8;
    localparam int NP   = NUM_PORTS;
    localparam int W    = SIZE + 1;  // {is_drop, item}

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 fifo_empty;
    logic [SIZE-1:0]      fifo_item_out;
    logic                 fifo_read;
    logic [NP-1:0]        tx_req;
    logic [NP-1:0]        tx_ack = '0;
    logic [NP*SIZE-1:0]   tx_data;
    logic                 drop;
    logic [7:0]           drop_count;

    tx_logic #(
        .id   (3),
        .SIZE (SIZE)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .fifo_empty    (fifo_empty),
        .fifo_item_out (fifo_item_out),
        .fifo_read     (fifo_read),
        .tx_req        (tx_req),
        .tx_ack        (tx_ack),
        .tx_data       (tx_data),
        .drop          (drop),
        .drop_count    (drop_count)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- FIFO model ----------------
    logic [SIZE-1:0] mem [0:1023];
    int head = 0;
    int tail = 0;

    assign fifo_empty    = (head == tail);
    assign fifo_item_out = mem[head];

    always @(posedge clk) begin
        if (fifo_read && (head != tail)) head <= head + 1;
    end

    // ---------------- scoreboard state ----------------
    int errors = 0;
    int checks = 0;
    int pop_cnt = 0;
    int pop_cyc[$];
    logic [W-1:0]    exp_q[$];
    logic [SIZE-1:0] rx_exp[$];
    int rx_delay[NP];
    logic [NP-1:0]   prev_req = '0;
    logic [W-1:0]    mon_e;
    int              mon_p;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [SIZE-1:0] slot(input int p);
        return tx_data[SIZE*p +: SIZE];
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (reset) begin
            prev_req = '0;
        end else begin
            if (fifo_read) begin
                pop_cnt++;
                pop_cyc.push_back(cyc);
                check("read_while_empty", 64'(fifo_empty), 64'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pop: got item %0h expected no pop", fifo_item_out);
                end else begin
                    mon_e = exp_q.pop_front();
                    mon_p = int'(mon_e[2:0]);
                    check("pop_item", 64'(fifo_item_out), 64'(mon_e[SIZE-1:0]));
                    if (mon_e[SIZE]) begin
                        check("drop_pulse", 64'(drop), 64'd1);
                        check("drop_req_hold", 64'(tx_req), 64'(prev_req));
                    end else begin
                        check("send_drop_low", 64'(drop), 64'd0);
                        check("send_req_toggle", 64'(tx_req),
                              64'(prev_req ^ (NP'(1) << mon_p)));
                        check("send_slot_data", 64'(slot(mon_p)), 64'(mon_e[SIZE-1:0]));
                    end
                end
            end else begin
                check("idle_req_hold", 64'(tx_req), 64'(prev_req));
                check("idle_drop_low", 64'(drop), 64'd0);
            end
            prev_req = tx_req;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push(input logic [SIZE-1:0] item, input logic exp_drop);
        mem[tail] = item;
        tail++;
        exp_q.push_back({exp_drop, item});
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (((head != tail) || fifo_read) && (n < 2000)) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain_in_time"}, 64'(n < 2000), 64'd1);
    endtask

    task automatic wait_pops(input int target);
        int n;
        n = 0;
        while ((pop_cnt < target) && (n < 200)) begin
            @(negedge clk);
            n++;
        end
        check("wait_pops_in_time", 64'(pop_cnt >= target), 64'd1);
    endtask

    // Receiver model: acks a busy port after a short random delay and checks
    // the data against the next expected item for that port.
    task automatic rx_step();
        for (int p = 0; p < NP; p++) begin
            if (tx_req[p] != tx_ack[p]) begin
                if (rx_delay[p] == 0) begin
                    int idx;
                    idx = -1;
                    for (int i = 0; i < rx_exp.size(); i++) begin
                        if ((idx < 0) && (int'(rx_exp[i][2:0]) == p)) idx = i;
                    end
                    if (idx < 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rx_unexpected: port %0d got %0h expected nothing", p, slot(p));
                    end else begin
                        check("rx_data_in_order", 64'(slot(p)), 64'(rx_exp[idx]));
                        rx_exp.delete(idx);
                    end
                    tx_ack[p] = ~tx_ack[p];
                    rx_delay[p] = $urandom_range(0, 4);
                end else begin
                    rx_delay[p]--;
                end
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int p = 0; p < NP; p++) rx_delay[p] = 0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req", 64'(tx_req), 64'd0);
        check("rst_data", 64'(tx_data), 64'd0);
        check("rst_read", 64'(fifo_read), 64'd0);
        check("rst_drop", 64'(drop), 64'd0);
        check("rst_drop_count", 64'(drop_count), 64'd0);
        reset = 1'b0;

        // single send to port 2
        push(8'h02, 1'b0);
        wait_drain("t1");
        check("t1_req", 64'(tx_req), 64'b00100);
        check("t1_slot2", 64'(slot(2)), 64'h02);
        check("t1_pops", 64'(pop_cnt), 64'd1);
        tx_ack[2] = ~tx_ack[2];

        // back-to-back sends on ports 1 and 3, no acks
        push(8'h01, 1'b0);
        push(8'h03, 1'b0);
        wait_drain("t2");
        check("t2_pops", 64'(pop_cnt), 64'd3);
        check("t2_gap", 64'(pop_cyc[2] - pop_cyc[1]), 64'd2);
        check("t2_req", 64'(tx_req), 64'b01110);
        check("t2_slot1", 64'(slot(1)), 64'h01);
        check("t2_slot3", 64'(slot(3)), 64'h03);
        tx_ack = 5'b01110;

        // head-of-line blocking on port 2
        push(8'h0A, 1'b0);
        push(8'h12, 1'b0);
        wait_pops(4);
        repeat (8) @(negedge clk);
        check("t3_stall_pops", 64'(pop_cnt), 64'd4);
        check("t3_stall_read", 64'(fifo_read), 64'd0);
        check("t3_head", 64'(fifo_item_out), 64'h12);
        check("t3_slot2_held", 64'(slot(2)), 64'h0A);
        tx_ack[2] = ~tx_ack[2];
        @(negedge clk);
        check("t3_release_read", 64'(fifo_read), 64'd1);
        check("t3_release_slot2", 64'(slot(2)), 64'h12);
        check("t3_release_req", 64'(tx_req), 64'b01110);
        wait_drain("t3");
        tx_ack[2] = ~tx_ack[2];

        // invalid port fields
        push(8'h07, 1'b1);
        wait_drain("t4a");
        check("t4_count_1", 64'(drop_count), 64'd1);
        check("t4_req_unchanged", 64'(tx_req), 64'b01110);
        for (int i = 1; i < 300; i++) begin
            case (i % 3)
                0:       push(8'h07, 1'b1);
                1:       push(8'hF5, 1'b1);
                default: push(8'h2E, 1'b1);
            endcase
        end
        wait_drain("t4b");
        check("t4_count_sat", 64'(drop_count), 64'd255);
        check("t4_req_still", 64'(tx_req), 64'b01110);
        check("t4_slot2_still", 64'(slot(2)), 64'h12);

        // reset during an outstanding transfer on port 4
        push(8'h04, 1'b0);
        wait_drain("t5");
        check("t5_req4_busy", 64'(tx_req), 64'b11110);
        check("t5_slot4", 64'(slot(4)), 64'h04);
        #2;
        reset = 1'b1;
        tx_ack = '0;
        #1;
        check("t5_rst_req", 64'(tx_req), 64'd0);
        check("t5_rst_data", 64'(tx_data), 64'd0);
        check("t5_rst_count", 64'(drop_count), 64'd0);
        check("t5_rst_read", 64'(fifo_read), 64'd0);
        repeat (2) begin
            @(negedge clk);
            check("t5_no_read_in_reset", 64'(fifo_read), 64'd0);
        end
        reset = 1'b0;
        push(8'h01, 1'b0);
        @(negedge clk);
        check("t5_first_decision", 64'(fifo_read), 64'd1);
        check("t5_first_req", 64'(tx_req), 64'b00010);
        wait_drain("t5b");
        tx_ack[1] = ~tx_ack[1];

        // end to end with the receiver model
        for (int i = 0; i < 20; i++) begin
            logic [2:0]      pf;
            logic [4:0]      hi;
            logic [SIZE-1:0] it;
            pf = 3'($urandom_range(0, 4));
            hi = 5'($urandom_range(0, 31));
            it = {hi, pf};
            push(it, 1'b0);
            rx_exp.push_back(it);
        end
        begin
            int n;
            n = 0;
            while (((rx_exp.size() != 0) || (head != tail) || (tx_req != tx_ack)) && (n < 3000)) begin
                @(negedge clk);
                rx_step();
                n++;
            end
        end
        check("t6_rx_left", 64'(rx_exp.size()), 64'd0);
        check("t6_all_free", 64'(tx_req), 64'(tx_ack));
        check("t6_exp_left", 64'(exp_q.size()), 64'd0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test expected finish by 500000");
        $fatal(1, "watchdog");
    end

endmodule
